// File: rtl/aabb_hit_collector_pkg.sv
// Shared types and constants for the AABB hit collector: input result, per-tag
// accumulation entry and the finalised closest-hit record.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 8
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 3
`endif
`ifndef MAX_16
`define MAX_16 16'sh7FFF
`endif

package aabb_hit_collector_pkg;

   localparam int WIDTH    = `WIDTH;
   localparam int Q_BITS   = `Q_BITS;
   localparam int TAG_SIZE = `TAG_SIZE;
   localparam int BOX_W    = 8;
   localparam int NUM_TAGS = 1 << TAG_SIZE;

   localparam logic signed [WIDTH-1:0] COLLECT_NO_HIT = `MAX_16;

   typedef struct packed {
      logic [BOX_W-1:0]        box;
      logic                    ray_hit;
      logic [TAG_SIZE-1:0]     tag;
      logic signed [WIDTH-1:0] tmin;
   } AABB_result;

   typedef struct packed {
      logic [TAG_SIZE-1:0]     tag;
      logic                    hit;
      logic signed [WIDTH-1:0] tmin;
      logic [BOX_W-1:0]        box;
   } ClosestHit;

   typedef struct packed {
      logic [7:0]              count;
      logic                    hit;
      logic signed [WIDTH-1:0] tmin;
      logic [BOX_W-1:0]        box;
   } CollectEntry;

   function automatic CollectEntry entry_reset();
      CollectEntry e;
      e.count = 8'd0;
      e.hit   = 1'b0;
      e.tmin  = COLLECT_NO_HIT;
      e.box   = '0;
      return e;
   endfunction

endpackage

// File: rtl/hit_result_fifo.sv
// Small synchronous FIFO of ClosestHit records. A push into a full FIFO only
// lands when a pop happens on the same edge; otherwise it is discarded.
module hit_result_fifo
   import aabb_hit_collector_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  ClosestHit push_data,
   input  logic      pop,
   output ClosestHit pop_data,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   ClosestHit       mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full     = (cnt_q == (AW+1)'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (do_push) mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/aabb_hit_collector.sv
// Collects AABB test results per ray tag, keeps the nearest hit and emits one
// ClosestHit per tag after BOX_COUNT results. AABB_COLLECT_STATS_EN adds counters.
module aabb_hit_collector
   import aabb_hit_collector_pkg::*;
#(
   parameter int BOX_COUNT = 8,
   parameter int OUT_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  AABB_result  in_result,
   output logic        out_valid,
   input  logic        out_ready,
   output ClosestHit   out_hit,
   output logic        overflow,
   output logic        busy
`ifdef AABB_COLLECT_STATS_EN
   ,
   output logic [31:0] stat_rays,
   output logic [31:0] stat_hits
`endif
);

   localparam logic [7:0] BOX_LIMIT = 8'(BOX_COUNT);

   CollectEntry         table_q [NUM_TAGS];
   CollectEntry         table_d [NUM_TAGS];
   CollectEntry         cur_entry, upd_entry;
   ClosestHit           fin_rec, head;
   logic                fin, push_ok;
   logic                fifo_full, fifo_empty, fifo_pop;
   logic                overflow_q, overflow_d;
   logic [NUM_TAGS-1:0] active;

   // Single-cycle read-modify-write; strict less-than keeps the earlier box on ties.
   always_comb begin
      cur_entry       = table_q[in_result.tag];
      upd_entry       = cur_entry;
      upd_entry.count = cur_entry.count + 8'd1;
      if (in_result.ray_hit && ($signed(in_result.tmin) < $signed(cur_entry.tmin))) begin
         upd_entry.hit  = 1'b1;
         upd_entry.tmin = in_result.tmin;
         upd_entry.box  = in_result.box;
      end
      fin          = in_valid && (upd_entry.count == BOX_LIMIT);
      fin_rec.tag  = in_result.tag;
      fin_rec.hit  = upd_entry.hit;
      fin_rec.tmin = upd_entry.tmin;
      fin_rec.box  = upd_entry.box;
      table_d      = table_q;
      if (in_valid) table_d[in_result.tag] = fin ? entry_reset() : upd_entry;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_TAGS; i++) table_q[i] <= entry_reset();
         overflow_q <= 1'b0;
      end else begin
         table_q    <= table_d;
         overflow_q <= overflow_d;
      end
   end

   assign fifo_pop   = out_valid && out_ready;
   assign push_ok    = fin && (!fifo_full || fifo_pop);
   assign overflow_d = overflow_q || (fin && fifo_full && !fifo_pop);

   hit_result_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fin),
      .push_data (fin_rec),
      .pop       (fifo_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_active
      assign active[gi] = (table_q[gi].count != 8'd0);
   end

   assign out_valid = !fifo_empty;
   assign out_hit   = fifo_empty ? '0 : head;
   assign overflow  = overflow_q;
   assign busy      = (|active) || !fifo_empty;

`ifdef AABB_COLLECT_STATS_EN
   logic [31:0] stat_rays_q, stat_rays_d;
   logic [31:0] stat_hits_q, stat_hits_d;

   always_comb begin
      stat_rays_d = stat_rays_q;
      stat_hits_d = stat_hits_q;
      if (push_ok) begin
         stat_rays_d = stat_rays_q + 32'd1;
         if (fin_rec.hit) stat_hits_d = stat_hits_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_rays_q <= '0;
         stat_hits_q <= '0;
      end else begin
         stat_rays_q <= stat_rays_d;
         stat_hits_q <= stat_hits_d;
      end
   end

   assign stat_rays = stat_rays_q;
   assign stat_hits = stat_hits_q;
`else
   logic unused_push_ok;
   assign unused_push_ok = push_ok;
`endif

endmodule

// File: tb/tb_aabb_hit_collector.sv
// Self-checking bench for aabb_hit_collector (BOX_COUNT=4, OUT_DEPTH=4) with a
// queue-based reference model of tag accumulation and the output FIFO.
module tb_aabb_hit_collector;
   import aabb_hit_collector_pkg::*;

   localparam int BC    = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   AABB_result in_result;
   logic       out_valid;
   logic       out_ready;
   ClosestHit  out_hit;
   logic       overflow;
   logic       busy;
`ifdef AABB_COLLECT_STATS_EN
   logic [31:0] stat_rays;
   logic [31:0] stat_hits;
`endif

   int checks = 0;
   int errors = 0;

   AABB_result pend_q[$];
   ClosestHit  exp_q[$];
   logic       ovf_m;

   always #5 clk = ~clk;

   aabb_hit_collector #(.BOX_COUNT(BC), .OUT_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_result (in_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_hit   (out_hit),
      .overflow  (overflow),
      .busy      (busy)
`ifdef AABB_COLLECT_STATS_EN
      ,
      .stat_rays (stat_rays),
      .stat_hits (stat_hits)
`endif
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chkh(input string tag, input ClosestHit obs, input ClosestHit exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed tag=%0d hit=%0b tmin=%0d box=%0d expected tag=%0d hit=%0b tmin=%0d box=%0d",
                tag, obs.tag, obs.hit, obs.tmin, obs.box, exp.tag, exp.hit, exp.tmin, exp.box);
      end
   endtask

   function automatic AABB_result mk(input int t, input logic h, input int tm, input int b);
      AABB_result r;
      r.tag     = TAG_SIZE'(t);
      r.ray_hit = h;
      r.tmin    = WIDTH'(tm);
      r.box     = BOX_W'(b);
      return r;
   endfunction

   function automatic ClosestHit rec(input int t, input logic h, input int tm, input int b);
      ClosestHit c;
      c.tag  = TAG_SIZE'(t);
      c.hit  = h;
      c.tmin = WIDTH'(tm);
      c.box  = BOX_W'(b);
      return c;
   endfunction

   // Nearest hit among all stored results of a tag, in arrival order.
   function automatic ClosestHit nearest(input logic [TAG_SIZE-1:0] t);
      ClosestHit c;
      c.tag  = t;
      c.hit  = 1'b0;
      c.tmin = COLLECT_NO_HIT;
      c.box  = '0;
      foreach (pend_q[i]) begin
         if (pend_q[i].tag == t && pend_q[i].ray_hit &&
             $signed(pend_q[i].tmin) < $signed(c.tmin)) begin
            c.hit  = 1'b1;
            c.tmin = pend_q[i].tmin;
            c.box  = pend_q[i].box;
         end
      end
      return c;
   endfunction

   function automatic int count_tag(input logic [TAG_SIZE-1:0] t);
      int n = 0;
      foreach (pend_q[i]) if (pend_q[i].tag == t) n++;
      return n;
   endfunction

   task automatic cycle(input logic v, input AABB_result r, input logic rdy);
      logic       pop, full;
      ClosestHit  c;
      AABB_result keep[$];
      in_valid  = v;
      in_result = r;
      out_ready = rdy;
      pop  = rdy && (exp_q.size() > 0);
      full = (exp_q.size() == DEPTH);
      @(posedge clk);
      if (pop) void'(exp_q.pop_front());
      if (v) begin
         pend_q.push_back(r);
         if (count_tag(r.tag) == BC) begin
            c = nearest(r.tag);
            foreach (pend_q[i]) if (pend_q[i].tag != r.tag) keep.push_back(pend_q[i]);
            pend_q = keep;
            if (!full || pop) exp_q.push_back(c);
            else ovf_m = 1'b1;
         end
      end
      #1;
      chk1("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) chkh("out_hit", out_hit, exp_q[0]);
      else                  chkh("out_hit_idle", out_hit, '0);
      chk1("overflow", overflow, ovf_m);
      chk1("busy", busy, (pend_q.size() > 0) || (exp_q.size() > 0));
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, '0, rdy);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_result = '0;
      #2;
      chk1("rst_out_valid", out_valid, 1'b0);
      chkh("rst_out_hit", out_hit, '0);
      chk1("rst_overflow", overflow, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      pend_q.delete();
      exp_q.delete();
      ovf_m = 1'b0;
   endtask

   task automatic feed_tag(input int t, input int base, input logic rdy);
      for (int i = 0; i < BC; i++) cycle(1'b1, mk(t, 1'b1, base - i * 16, t * 16 + i), rdy);
   endtask

   initial begin
      do_reset();

      // Tag 3: nearest is the second input.
      cycle(1'b1, mk(3, 1'b1, 1280, 1), 1'b0);
      cycle(1'b1, mk(3, 1'b1, 512, 2), 1'b0);
      cycle(1'b1, mk(3, 1'b1, 2304, 3), 1'b0);
      chk1("t3_not_yet", out_valid, 1'b0);
      cycle(1'b1, mk(3, 1'b0, 0, 4), 1'b0);
      chkh("t3_record", out_hit, rec(3, 1'b1, 512, 2));
      idle(1'b1);

      // Tag 1: misses only.
      for (int i = 0; i < BC; i++) cycle(1'b1, mk(1, 1'b0, 100 * i, 40 + i), 1'b0);
      chkh("t1_miss_record", out_hit, rec(1, 1'b0, int'(COLLECT_NO_HIT), 0));
      idle(1'b1);
      chk1("t1_busy_after_pop", busy, 1'b0);

      // Interleaved tags 0 and 1.
      cycle(1'b1, mk(0, 1'b1, 768, 10), 1'b0);
      cycle(1'b1, mk(1, 1'b1, 1792, 20), 1'b0);
      cycle(1'b1, mk(0, 1'b1, 768, 11), 1'b0);
      cycle(1'b1, mk(1, 1'b0, 0, 23), 1'b0);
      cycle(1'b1, mk(0, 1'b1, 1024, 12), 1'b0);
      cycle(1'b1, mk(1, 1'b1, 1536, 21), 1'b0);
      cycle(1'b1, mk(0, 1'b1, 384, 13), 1'b0);
      chkh("ilv_tag0_first", out_hit, rec(0, 1'b1, 384, 13));
      cycle(1'b1, mk(1, 1'b1, -256, 22), 1'b0);
      idle(1'b1);
      chkh("ilv_tag1_second", out_hit, rec(1, 1'b1, -256, 22));
      idle(1'b1);

      // Tie at 3.0 keeps the first box.
      cycle(1'b1, mk(2, 1'b1, 768, 5), 1'b0);
      cycle(1'b1, mk(2, 1'b1, 768, 6), 1'b0);
      cycle(1'b1, mk(2, 1'b1, 1024, 7), 1'b0);
      cycle(1'b1, mk(2, 1'b0, 0, 8), 1'b0);
      chkh("tie_first_box", out_hit, rec(2, 1'b1, 768, 5));
      idle(1'b1);

      // Fill FIFO, then a finalise with a simultaneous pop, then a dropped record.
      for (int t = 0; t < 4; t++) feed_tag(t, 2000 + t, 1'b0);
      chkh("full_head", out_hit, rec(0, 1'b1, 2000 - 48, 3));
      for (int i = 0; i < BC - 1; i++) cycle(1'b1, mk(4, 1'b1, 500 + i, 64 + i), 1'b0);
      cycle(1'b1, mk(4, 1'b1, 100, 70), 1'b1);
      chk1("full_pop_push_no_ovf", overflow, 1'b0);
      chkh("full_pop_push_head", out_hit, rec(1, 1'b1, 2001 - 48, 19));
      feed_tag(5, 3000, 1'b0);
      chk1("drop_sets_ovf", overflow, 1'b1);
      for (int i = 0; i < DEPTH; i++) idle(1'b1);
      chk1("drained", out_valid, 1'b0);
      chk1("drained_busy", busy, 1'b0);
      chk1("ovf_sticky", overflow, 1'b1);

      // Reset mid-accumulation.
      cycle(1'b1, mk(6, 1'b1, 900, 1), 1'b0);
      cycle(1'b1, mk(6, 1'b1, 200, 2), 1'b0);
      do_reset();
      cycle(1'b1, mk(6, 1'b1, 700, 3), 1'b0);
      cycle(1'b1, mk(6, 1'b0, 0, 4), 1'b0);
      cycle(1'b1, mk(6, 1'b1, -50, 5), 1'b0);
      cycle(1'b1, mk(6, 1'b1, 800, 6), 1'b0);
      chkh("post_reset_record", out_hit, rec(6, 1'b1, -50, 5));
      idle(1'b1);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 3) != 0,
               mk($urandom_range(0, NUM_TAGS - 1), 1'($urandom_range(0, 1)),
                  int'($signed(WIDTH'($urandom))), $urandom_range(0, 255)),
               $urandom_range(0, 2) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
